full_sub: RTL and testbench
===========================

FULL_SUB -- requirements
Module: full_sub

Interface
REQ-001 Parameter REG_OUT, default 0: 0 = outputs d/bo/out_valid combinational; 1 = registered with 1-cycle latency.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 a  input  1  minuend bit.
REQ-005 b  input  1  subtrahend bit.
REQ-006 bi  input  1  borrow-in, used when serial_en=0.
REQ-007 in_valid  input  1  operands valid this cycle; integrators tie it to 1 when unused.
REQ-008 serial_en  input  1  1 = borrow-in taken from internal borrow register (bit-serial chaining); tie to 0 when unused.
REQ-009 d  output  1  difference bit.
REQ-010 bo  output  1  borrow-out.
REQ-011 out_valid  output  1  d/bo correspond to a valid operand set.

Function
REQ-012 Effective borrow-in bin_eff = serial_en ? borrow_q : bi.
REQ-013 Difference: d = a XOR b XOR bin_eff.
REQ-014 Borrow-out: bo = (~a & b) | (~a & bin_eff) | (b & bin_eff), i.e. 1 exactly when a < b + bin_eff.
REQ-015 REG_OUT=0: d, bo follow inputs with zero cycle latency; out_valid = in_valid.
REQ-016 REG_OUT=1: d, bo, out_valid are registered copies of the REQ-013/014 values and in_valid, updated each rising clk edge (1-cycle latency).
REQ-017 REG_OUT=1: when in_valid=0 at a clock edge, d and bo hold their previous values and out_valid goes 0.
REQ-018 borrow_q (1 bit) loads the computed bo on every rising edge with in_valid=1, regardless of serial_en; it holds when in_valid=0.
REQ-019 Bit-serial use: operands presented LSB first with serial_en=1; the first bit is presented with serial_en=0 and bi=0, or immediately after reset.
REQ-020 No X propagation from internal state: all registers have defined reset values.

Reset
REQ-021 rst_n low asynchronously clears borrow_q to 0.
REQ-022 rst_n low asynchronously clears registered d, bo, out_valid to 0 (REG_OUT=1).
REQ-023 REG_OUT=0: combinational d/bo are unaffected by reset except through borrow_q when serial_en=1.
REQ-024 Reset mid-serial-operation aborts the chain; the next valid bit uses borrow_q=0.

Structure
REQ-025 The combinational difference/borrow equations live in one sub-module, full_sub_cell (ports a, b, bin, d, bo), instantiated once.
REQ-026 Shared package holds nothing beyond an optional 1-bit borrow typedef; REG_OUT stays a module parameter.
REQ-027 The top module contains only bin_eff mux, borrow_q register and the REG_OUT generate branch.

Verification
REQ-028 REG_OUT=0, serial_en=0, in_valid=1: sweep (a,b,bi) 000..111 every 2 time units -> (d,bo) = 00,11,11,01,10,00,00,11.
REQ-029 REG_OUT=1: apply a=0,b=1,bi=0 with in_valid=1 -> d=1, bo=1, out_valid=1 one clk edge later, not before.
REQ-030 Serial 3-5 (a=011, b=101, LSB first, first bit serial_en=0 bi=0, then serial_en=1) -> d bits 0,1,1 (result 110) with final bo=1.
REQ-031 Assert rst_n=0 asynchronously between clock edges after a bo=1 bit -> borrow_q and registered outputs read 0 immediately; next serial bit a=1,b=0 gives d=1,bo=0.
REQ-032 REG_OUT=1, in_valid=0 for 3 cycles with toggling a/b -> d/bo held, out_valid=0, borrow_q unchanged.

Source files
------------

// File: rtl/full_sub_pkg.sv
// full_sub_pkg: shared borrow type for the full subtractor slice
package full_sub_pkg;
  typedef logic borrow_t;
endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell: combinational one-bit difference and borrow equations
module full_sub_cell
  import full_sub_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  borrow_t bin,
  output logic    d,
  output borrow_t bo
);
  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/full_sub.sv
// full_sub: one-bit full subtractor with bit-serial borrow chaining and optional output register
module full_sub
  import full_sub_pkg::*;
#(
  parameter bit REG_OUT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic bi,
  input  logic in_valid,
  input  logic serial_en,
  output logic d,
  output logic bo,
  output logic out_valid
);
  borrow_t borrow_q;
  borrow_t borrow_d;
  borrow_t bin_eff;
  logic    diff_d;
  assign bin_eff = serial_en ? borrow_q : bi;
  full_sub_cell u_cell (
    .a  (a),
    .b  (b),
    .bin(bin_eff),
    .d  (diff_d),
    .bo (borrow_d)
  );
  // carry the borrow to the next serial bit on every valid operand set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) borrow_q <= 1'b0;
    else if (in_valid) borrow_q <= borrow_d;
  generate
    if (REG_OUT) begin : g_reg
      logic d_q, bo_q, valid_q;
      // register the result; hold d/bo across invalid cycles while valid drops
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          d_q     <= 1'b0;
          bo_q    <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= in_valid;
          if (in_valid) begin
            d_q  <= diff_d;
            bo_q <= borrow_d;
          end
        end
      assign d         = d_q;
      assign bo        = bo_q;
      assign out_valid = valid_q;
    end else begin : g_comb
      assign d         = diff_d;
      assign bo        = borrow_d;
      assign out_valid = in_valid;
    end
  endgenerate
endmodule

// File: tb/tb_full_sub.sv
// tb_full_sub: directed checks of combinational and registered full_sub variants side by side
module tb_full_sub;
  logic clk = 1'b0;
  logic rst_n, a, b, bi, in_valid, serial_en;
  logic d0, bo0, v0, d1, bo1, v1;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] sweep_exp [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
  logic [2:0] ser_a = 3'b011;
  logic [2:0] ser_b = 3'b101;
  logic [2:0] ser_d = 3'b110;
  logic [2:0] ser_bo = 3'b100;

  always #5 clk = ~clk;

  full_sub #(.REG_OUT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .bi(bi), .in_valid(in_valid),
    .serial_en(serial_en), .d(d0), .bo(bo0), .out_valid(v0)
  );
  full_sub #(.REG_OUT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .bi(bi), .in_valid(in_valid),
    .serial_en(serial_en), .d(d1), .bo(bo1), .out_valid(v1)
  );

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a = 1'b0; b = 1'b0; bi = 1'b0; in_valid = 1'b1; serial_en = 1'b0;
    #3;
    chk("reset_reg_out", {d1, bo1, v1}, 3'b000);
    chk("reset_borrow", {1'b0, u0.borrow_q, u1.borrow_q}, 3'b000);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {a, b, bi} = 3'(i);
      #1;
      chk($sformatf("sweep_%0d", i), {v0, d0, bo0}, {1'b1, sweep_exp[i]});
      #1;
    end
    step();
    a = 1'b0; b = 1'b0; bi = 1'b0;
    step();
    chk("reg_pre", {d1, bo1, v1}, 3'b001);
    a = 1'b0; b = 1'b1; bi = 1'b0;
    #1;
    chk("comb_0_1_0", {v0, d0, bo0}, 3'b111);
    chk("reg_not_before", {d1, bo1, v1}, 3'b001);
    step();
    chk("reg_latency", {d1, bo1, v1}, 3'b111);
    for (int i = 0; i < 3; i++) begin
      a = ser_a[i]; b = ser_b[i]; bi = 1'b0; serial_en = (i != 0);
      #1;
      chk($sformatf("serial_comb_%0d", i), {1'b0, d0, bo0}, {1'b0, ser_d[i], ser_bo[i]});
      step();
      chk($sformatf("serial_reg_%0d", i), {d1, bo1, v1}, {ser_d[i], ser_bo[i], 1'b1});
    end
    chk("serial_borrow", {1'b0, u0.borrow_q, u1.borrow_q}, 3'b011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_borrow", {1'b0, u0.borrow_q, u1.borrow_q}, 3'b000);
    chk("async_reg_out", {d1, bo1, v1}, 3'b000);
    rst_n = 1'b1;
    a = 1'b1; b = 1'b0; serial_en = 1'b1;
    #1;
    chk("post_reset_comb", {1'b0, d0, bo0}, 3'b010);
    step();
    chk("post_reset_reg", {d1, bo1, v1}, 3'b101);
    a = 1'b0; b = 1'b1; bi = 1'b0; serial_en = 1'b0;
    step();
    chk("hold_setup", {d1, bo1, v1}, 3'b111);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = ~a; b = ~b; bi = ~bi;
      #1;
      chk($sformatf("hold_comb_valid_%0d", i), {2'b00, v0}, 3'b000);
      step();
      chk($sformatf("hold_reg_%0d", i), {d1, bo1, v1}, 3'b110);
      chk($sformatf("hold_borrow_%0d", i), {1'b0, u0.borrow_q, u1.borrow_q}, 3'b011);
    end
    in_valid = 1'b1; a = 1'b1; b = 1'b0; serial_en = 1'b1;
    #1;
    chk("resume_comb", {v0, d0, bo0}, 3'b100);
    step();
    chk("resume_reg", {d1, bo1, v1}, 3'b001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
